// File: rtl/is_flush_equiv_tracker_pkg.sv
// -----------------------------------------------------------------------------
// is_equiv_pkg
// Shared definitions for the A/B flush-equivalence tracker:
//   - trk_state_e  : tracker phase (IDLE/FLUSH/DONE/ERR), encoded as the
//                    2-bit state output seen by the harness
//   - lane_idx_w() : width of a lane index (at least 1 bit)
//   - OUT_MASK_ALL : wide all-ones constant; the top slices it to NUM_CH bits
//                    so that, by default, every lane is treated as an output
// -----------------------------------------------------------------------------
package is_equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } trk_state_e;

  localparam logic [255:0] OUT_MASK_ALL = '1;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/is_flush_equiv_tracker_if.sv
// -----------------------------------------------------------------------------
// is_flush_equiv_tracker_if
// Bundles the lane buses, the flush/drain handshake of both copies and the
// tracker status outputs.
//   master : drives the copy A/B lanes and handshakes, observes the status
//   slave  : the tracker; consumes lanes/handshakes, drives the status
// Lane i occupies a_dat/b_dat[i*DAT_W +: DAT_W].
// -----------------------------------------------------------------------------
interface is_flush_equiv_tracker_if
  import is_equiv_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DAT_W  = 64,
  parameter int CNT_W  = 5
);
  localparam int LIDX_W = lane_idx_w(NUM_CH);

  logic [NUM_CH-1:0]       a_val;
  logic [NUM_CH-1:0]       b_val;
  logic [NUM_CH*DAT_W-1:0] a_dat;
  logic [NUM_CH*DAT_W-1:0] b_dat;
  logic [NUM_CH-1:0]       cmp_en;
  logic                    a_flush_req;
  logic                    b_flush_req;
  logic                    a_busy;
  logic                    b_busy;
  logic                    a_idle;
  logic                    b_idle;

  logic [1:0]              state;
  logic                    flush_began;
  logic                    flush_ended;
  logic                    io_equal;
  logic [CNT_W-1:0]        equal_cnt;
  logic                    mismatch;
  logic [LIDX_W-1:0]       mismatch_lane;
  logic                    timeout;

  modport master (
    output a_val, b_val, a_dat, b_dat, cmp_en,
    output a_flush_req, b_flush_req, a_busy, b_busy, a_idle, b_idle,
    input  state, flush_began, flush_ended, io_equal, equal_cnt,
    input  mismatch, mismatch_lane, timeout
  );

  modport slave (
    input  a_val, b_val, a_dat, b_dat, cmp_en,
    input  a_flush_req, b_flush_req, a_busy, b_busy, a_idle, b_idle,
    output state, flush_began, flush_ended, io_equal, equal_cnt,
    output mismatch, mismatch_lane, timeout
  );

endinterface

// File: rtl/is_flush_equiv_tracker_lane_cmp.sv
// -----------------------------------------------------------------------------
// is_lane_cmp
// Equality test for one A/B lane pair.
//   a_val, b_val : lane valids of copy A / copy B
//   a_dat, b_dat : lane data of copy A / copy B
//   cmp_en       : lane participates in the comparison
//   lane_eq      : lane counts as equal this cycle (always 1 when disabled)
// With DATA_GATE=1 the data is only meaningful while the lane is valid, so an
// idle lane (both valids low) is equal whatever its data holds.
// -----------------------------------------------------------------------------
module is_lane_cmp #(
  parameter int DAT_W     = 64,
  parameter bit DATA_GATE = 1'b1
) (
  input  logic             a_val,
  input  logic             b_val,
  input  logic [DAT_W-1:0] a_dat,
  input  logic [DAT_W-1:0] b_dat,
  input  logic             cmp_en,
  output logic             lane_eq
);

  logic dat_same;
  logic data_ok;

  assign dat_same = (a_dat == b_dat);

  if (DATA_GATE) begin : g_gated
    assign data_ok = !a_val || dat_same;
  end else begin : g_ungated
    assign data_ok = dat_same;
  end

  assign lane_eq = !cmp_en || ((a_val == b_val) && data_ok);

endmodule

// File: rtl/is_flush_equiv_tracker.sv
// -----------------------------------------------------------------------------
// is_flush_equiv_tracker
// Tracks a two-copy (A/B) equivalence run: counts consecutive all-equal
// cycles, starts a flush phase when both copies request invalidation after a
// long enough equal run, waits for both copies to drain, then watches the
// output lanes (OUT_MASK=1) for divergence.
//   clk_gated : clock
//   rst_f     : synchronous active-high reset
//   bus       : slave side of is_flush_equiv_tracker_if (lanes, flush/drain
//               handshakes, state/flags/counters)
// io_equal is combinational; every other output is registered.
// -----------------------------------------------------------------------------
module is_flush_equiv_tracker
  import is_equiv_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter int                DAT_W     = 64,
  parameter int                CNT_W     = 5,
  parameter int                EQ_THRESH = 8,
  parameter int                FLUSH_TMO = 256,
  parameter logic [NUM_CH-1:0] OUT_MASK  = OUT_MASK_ALL[NUM_CH-1:0],
  parameter bit                DATA_GATE = 1'b1
) (
  input  logic                   clk_gated,
  input  logic                   rst_f,
  is_flush_equiv_tracker_if.slave bus
);

  localparam int LIDX_W = lane_idx_w(NUM_CH);
  localparam int TMR_W  = $clog2(FLUSH_TMO + 1) + 1;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TMR_W-1:0] sat_inc_tmr(input logic [TMR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_CH-1:0] lane_eq;
  logic [NUM_CH-1:0] out_diff;
  logic [LIDX_W-1:0] low_idx;
  logic              io_equal;
  logic              start;
  logic              drained;
  logic              tmo_hit;

  trk_state_e        state_p1;
  trk_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt_p1;
  logic [TMR_W-1:0]  tmr_p1;
  logic              began_p1;
  logic              mis_p1;
  logic [LIDX_W-1:0] lane_p1;
  logic              tmo_p1;
  logic              ended;

  // ---- combinational lane compare -----------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    is_lane_cmp #(
      .DAT_W    (DAT_W),
      .DATA_GATE(DATA_GATE)
    ) u_cmp (
      .a_val  (bus.a_val[i]),
      .b_val  (bus.b_val[i]),
      .a_dat  (bus.a_dat[i*DAT_W +: DAT_W]),
      .b_dat  (bus.b_dat[i*DAT_W +: DAT_W]),
      .cmp_en (bus.cmp_en[i]),
      .lane_eq(lane_eq[i])
    );
  end

  assign io_equal = &lane_eq;
  assign out_diff = OUT_MASK & bus.cmp_en & ~lane_eq;

  // Scan from the top down so the lowest diverging lane is the last writer.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (out_diff[i]) low_idx = LIDX_W'(i);
    end
  end

  assign start   = (int'(cnt_p1) > EQ_THRESH) && io_equal &&
                   bus.a_flush_req && bus.b_flush_req;
  // Only output lanes must fall quiet; input lanes are held equal by the harness.
  assign drained = !bus.a_busy && !bus.b_busy && bus.a_idle && bus.b_idle &&
                   !(|((bus.a_val | bus.b_val) & OUT_MASK));
  // tmr_p1 holds the FLUSH cycles already spent, so this is the FLUSH_TMO-th one.
  assign tmo_hit = (FLUSH_TMO != 0) && ((int'(tmr_p1) + 1) >= FLUSH_TMO);

  // ---- FSM: state register ----------------------------------------------------
  always_ff @(posedge clk_gated) begin
    if (rst_f) state_p1 <= ST_IDLE;
    else       state_p1 <= state_nxt;
  end

  // ---- FSM: next state --------------------------------------------------------
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_IDLE:  if (start) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        // A drain on the very cycle the timer expires still counts as clean.
        if (drained)      state_nxt = ST_DONE;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_DONE:  if (|out_diff) state_nxt = ST_ERR;
      default:  state_nxt = ST_ERR;
    endcase
  end

  // ---- FSM: outputs -----------------------------------------------------------
  always_comb begin
    ended = (state_p1 == ST_DONE) || (state_p1 == ST_ERR);
  end

  // ---- registered counters and sticky flags -----------------------------------
  always_ff @(posedge clk_gated) begin
    if (rst_f) begin
      cnt_p1   <= '0;
      tmr_p1   <= '0;
      began_p1 <= 1'b0;
      mis_p1   <= 1'b0;
      lane_p1  <= '0;
      tmo_p1   <= 1'b0;
    end else begin
      cnt_p1 <= io_equal ? sat_inc_cnt(cnt_p1) : '0;
      case (state_p1)
        ST_IDLE: begin
          if (start) begin
            began_p1 <= 1'b1;
            tmr_p1   <= '0;
          end
        end
        ST_FLUSH: begin
          tmr_p1 <= sat_inc_tmr(tmr_p1);
          if (!drained && tmo_hit) tmo_p1 <= 1'b1;
        end
        ST_DONE: begin
          if (|out_diff) begin
            mis_p1 <= 1'b1;
            if (!mis_p1) lane_p1 <= low_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.io_equal      = io_equal;
  assign bus.state         = state_p1;
  assign bus.flush_began   = began_p1;
  assign bus.flush_ended   = ended;
  assign bus.equal_cnt     = cnt_p1;
  assign bus.mismatch      = mis_p1;
  assign bus.mismatch_lane = lane_p1;
  assign bus.timeout       = tmo_p1;

endmodule

// File: tb/tb_is_flush_equiv_tracker.sv
// -----------------------------------------------------------------------------
// tb_is_flush_equiv_tracker
// Two trackers share one stimulus stream:
//   u_dut0 : DATA_GATE=1, FLUSH_TMO=4, OUT_MASK=8'hF6 (lanes 0 and 3 are inputs)
//   u_dut1 : DATA_GATE=0, FLUSH_TMO=0, all lanes are outputs
// Each is checked every cycle against a behavioural model of the phase rules.
// -----------------------------------------------------------------------------
module tb_is_flush_equiv_tracker;

  localparam int NCH  = 8;
  localparam int DW   = 64;
  localparam int CW   = 5;
  localparam int EQT  = 8;
  localparam int CMAX = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   a_val, b_val, cmp_en;
  logic [NCH*DW-1:0] a_dat, b_dat;
  logic             a_req, b_req, a_busy, b_busy, a_idle, b_idle;

  always #5 clk = ~clk;

  is_flush_equiv_tracker_if #(.NUM_CH(NCH), .DAT_W(DW), .CNT_W(CW)) if0 ();
  is_flush_equiv_tracker_if #(.NUM_CH(NCH), .DAT_W(DW), .CNT_W(CW)) if1 ();

  assign if0.a_val = a_val;   assign if1.a_val = a_val;
  assign if0.b_val = b_val;   assign if1.b_val = b_val;
  assign if0.a_dat = a_dat;   assign if1.a_dat = a_dat;
  assign if0.b_dat = b_dat;   assign if1.b_dat = b_dat;
  assign if0.cmp_en = cmp_en; assign if1.cmp_en = cmp_en;
  assign if0.a_flush_req = a_req; assign if1.a_flush_req = a_req;
  assign if0.b_flush_req = b_req; assign if1.b_flush_req = b_req;
  assign if0.a_busy = a_busy; assign if1.a_busy = a_busy;
  assign if0.b_busy = b_busy; assign if1.b_busy = b_busy;
  assign if0.a_idle = a_idle; assign if1.a_idle = a_idle;
  assign if0.b_idle = b_idle; assign if1.b_idle = b_idle;

  is_flush_equiv_tracker #(
    .NUM_CH(NCH), .DAT_W(DW), .CNT_W(CW), .EQ_THRESH(EQT),
    .FLUSH_TMO(4), .OUT_MASK(8'hF6), .DATA_GATE(1'b1)
  ) u_dut0 (.clk_gated(clk), .rst_f(rst), .bus(if0.slave));

  is_flush_equiv_tracker #(
    .NUM_CH(NCH), .DAT_W(DW), .CNT_W(CW), .EQ_THRESH(EQT),
    .FLUSH_TMO(0), .OUT_MASK(8'hFF), .DATA_GATE(1'b0)
  ) u_dut1 (.clk_gated(clk), .rst_f(rst), .bus(if1.slave));

  logic [1:0]    o_state [2];
  logic          o_began [2], o_ended [2], o_eq [2], o_mis [2], o_tmo [2];
  logic [CW-1:0] o_cnt   [2];
  logic [2:0]    o_lane  [2];

  assign o_state[0] = if0.state;         assign o_state[1] = if1.state;
  assign o_began[0] = if0.flush_began;   assign o_began[1] = if1.flush_began;
  assign o_ended[0] = if0.flush_ended;   assign o_ended[1] = if1.flush_ended;
  assign o_eq[0]    = if0.io_equal;      assign o_eq[1]    = if1.io_equal;
  assign o_mis[0]   = if0.mismatch;      assign o_mis[1]   = if1.mismatch;
  assign o_tmo[0]   = if0.timeout;       assign o_tmo[1]   = if1.timeout;
  assign o_cnt[0]   = if0.equal_cnt;     assign o_cnt[1]   = if1.equal_cnt;
  assign o_lane[0]  = if0.mismatch_lane; assign o_lane[1]  = if1.mismatch_lane;

  // ---- reference model ----------------------------------------------------
  function automatic int p_tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic logic [NCH-1:0] p_mask(input int k);
    return (k == 0) ? 8'hF6 : 8'hFF;
  endfunction

  function automatic bit p_gate(input int k);
    return (k == 0);
  endfunction

  // phase: 0 idle, 1 flushing, 2 drained/done, 3 error
  int m_st [2], m_cnt [2], m_tmr [2], m_lane [2];
  bit m_began [2], m_mis [2], m_tmo [2];

  function automatic bit m_lane_ok(input int k, input int i);
    logic [DW-1:0] da, db;
    da = a_dat[i*DW +: DW];
    db = b_dat[i*DW +: DW];
    if (!cmp_en[i]) return 1'b1;
    if (a_val[i] != b_val[i]) return 1'b0;
    if (p_gate(k) && !a_val[i]) return 1'b1;
    return (da == db);
  endfunction

  function automatic bit m_eq(input int k);
    bit all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < NCH; i++) if (!m_lane_ok(k, i)) all_ok = 1'b0;
    return all_ok;
  endfunction

  task automatic m_step(input int k);
    bit eq, drained, start;
    int first;
    logic [NCH-1:0] om;
    om      = p_mask(k);
    eq      = m_eq(k);
    drained = !a_busy && !b_busy && a_idle && b_idle && (((a_val | b_val) & om) == '0);
    start   = eq && a_req && b_req && (m_cnt[k] > EQT);
    first   = -1;
    for (int i = 0; i < NCH; i++)
      if (first < 0 && om[i] && !m_lane_ok(k, i)) first = i;
    if (rst) begin
      m_st[k] = 0; m_cnt[k] = 0; m_tmr[k] = 0; m_lane[k] = 0;
      m_began[k] = 0; m_mis[k] = 0; m_tmo[k] = 0;
      return;
    end
    case (m_st[k])
      0: if (start) begin m_st[k] = 1; m_began[k] = 1; m_tmr[k] = 0; end
      1: begin
        m_tmr[k]++;
        if (drained) m_st[k] = 2;
        else if (p_tmo(k) != 0 && m_tmr[k] >= p_tmo(k)) begin m_st[k] = 3; m_tmo[k] = 1; end
      end
      2: if (first >= 0) begin
        if (!m_mis[k]) m_lane[k] = first;
        m_mis[k] = 1;
        m_st[k]  = 3;
      end
      default: ;
    endcase
    m_cnt[k] = eq ? ((m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1) : 0;
  endtask

  // ---- checking -------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check io_equal on the settled inputs, advance the model,
  // then check the registered outputs just after the edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("u%0d.io_equal", k), 64'(o_eq[k]), 64'(m_eq(k)));
    for (int k = 0; k < 2; k++) m_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.state", k),       64'(o_state[k]), 64'(m_st[k]));
      check($sformatf("u%0d.equal_cnt", k),   64'(o_cnt[k]),   64'(m_cnt[k]));
      check($sformatf("u%0d.flush_began", k), 64'(o_began[k]), 64'(m_began[k]));
      check($sformatf("u%0d.flush_ended", k), 64'(o_ended[k]), 64'(m_st[k] >= 2));
      check($sformatf("u%0d.mismatch", k),    64'(o_mis[k]),   64'(m_mis[k]));
      check($sformatf("u%0d.mis_lane", k),    64'(o_lane[k]),  64'(m_lane[k]));
      check($sformatf("u%0d.timeout", k),     64'(o_tmo[k]),   64'(m_tmo[k]));
    end
  endtask

  // ---- stimulus helpers -----------------------------------------------------
  task automatic rand_data();
    for (int i = 0; i < NCH; i++) a_dat[i*DW +: DW] = {$urandom, $urandom};
    b_dat = a_dat;
  endtask

  task automatic quiet();
    a_req = 0; b_req = 0; a_busy = 0; b_busy = 0; a_idle = 1; b_idle = 1;
    cmp_en = '1;
  endtask

  task automatic eq_cycle(input logic [NCH-1:0] v);
    a_val = v; b_val = v; rand_data();
    cycle();
  endtask

  task automatic do_reset();
    quiet();
    rst = 1; a_val = '0; b_val = '0; rand_data();
    cycle();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.rst_state", k), 64'(o_state[k]), 64'd0);
      check($sformatf("u%0d.rst_cnt", k),   64'(o_cnt[k]),   64'd0);
      check($sformatf("u%0d.rst_began", k), 64'(o_began[k]), 64'd0);
      check($sformatf("u%0d.rst_mis", k),   64'(o_mis[k]),   64'd0);
      check($sformatf("u%0d.rst_tmo", k),   64'(o_tmo[k]),   64'd0);
    end
  endtask

  // n equal cycles, then one equal cycle carrying both flush requests.
  task automatic enter_flush(input int n);
    repeat (n) eq_cycle(NCH'($urandom));
    a_req = 1; b_req = 1;
    eq_cycle(NCH'($urandom));
    a_req = 0; b_req = 0;
  endtask

  initial begin
    int r, j;
    quiet();
    rst = 1; a_val = '0; b_val = '0; rand_data();

    // Flush entry after a 9-cycle run, staggered drain, then DONE divergence.
    do_reset();
    enter_flush(9);
    check("dir.flush_state", 64'(o_state[1]), 64'd1);
    check("dir.flush_began", 64'(o_began[1]), 64'd1);
    check("dir.flush_cnt",   64'(o_cnt[1]),   64'd10);
    b_idle = 0;
    for (int c = 1; c <= 5; c++) begin
      a_busy = (c < 3);
      b_idle = (c >= 5);
      eq_cycle('0);
      if (c == 4) check("dir.still_flush", 64'(o_state[1]), 64'd1);
    end
    check("dir.done_state", 64'(o_state[1]), 64'd2);
    check("dir.done_ended", 64'(o_ended[1]), 64'd1);
    check("dir.tmo0_err",   64'(o_state[0]), 64'd3);
    a_val = 8'h24; b_val = 8'h24; rand_data();
    b_dat[2*DW +: DW] = ~a_dat[2*DW +: DW];
    b_dat[5*DW +: DW] = ~a_dat[5*DW +: DW];
    cycle();
    check("dir.mis_flag",  64'(o_mis[1]),   64'd1);
    check("dir.mis_lane",  64'(o_lane[1]),  64'd2);
    check("dir.mis_state", 64'(o_state[1]), 64'd3);
    a_val = 8'h02; b_val = 8'h02; rand_data();
    b_dat[1*DW +: DW] = ~a_dat[1*DW +: DW];
    cycle();
    check("dir.mis_lane_hold", 64'(o_lane[1]), 64'd2);

    // Run of exactly EQ_THRESH is not enough; a single-copy request is ignored.
    do_reset();
    enter_flush(8);
    check("dir.thresh_idle", 64'(o_state[1]), 64'd0);
    a_req = 1;
    eq_cycle(NCH'($urandom));
    a_req = 0;
    check("dir.single_req_idle", 64'(o_state[1]), 64'd0);

    // Timeout with b_busy stuck, then a drain landing on the last allowed cycle.
    do_reset();
    enter_flush(9);
    b_busy = 1;
    repeat (4) eq_cycle('0);
    check("dir.tmo_state", 64'(o_state[0]), 64'd3);
    check("dir.tmo_flag",  64'(o_tmo[0]),   64'd1);
    do_reset();
    enter_flush(9);
    for (int c = 1; c <= 4; c++) begin
      b_busy = (c < 4);
      eq_cycle('0);
    end
    check("dir.tmo_race_state", 64'(o_state[0]), 64'd2);
    check("dir.tmo_race_flag",  64'(o_tmo[0]),   64'd0);

    // Counter saturation, then reset in the middle of FLUSH.
    do_reset();
    repeat (40) eq_cycle(NCH'($urandom));
    check("dir.sat_cnt", 64'(o_cnt[1]), 64'd31);
    a_req = 1; b_req = 1;
    eq_cycle(NCH'($urandom));
    a_req = 0; b_req = 0;
    b_busy = 1;
    repeat (2) eq_cycle('0);
    check("dir.pre_rst_flush", 64'(o_state[1]), 64'd1);
    rst = 1;
    eq_cycle('0);
    rst = 0;
    check("dir.rst_state", 64'(o_state[1]), 64'd0);
    check("dir.rst_began", 64'(o_began[1]), 64'd0);
    check("dir.rst_cnt",   64'(o_cnt[1]),   64'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 2);
      a_val = (r == 0) ? '0 : (r == 1) ? NCH'($urandom & $urandom) : NCH'($urandom);
      b_val = a_val;
      rand_data();
      cmp_en = ($urandom_range(0, 3) != 0) ? '1 : NCH'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        j = $urandom_range(0, NCH - 1);
        if ($urandom_range(0, 1) == 1) b_val[j] = ~b_val[j];
        else b_dat[j*DW +: DW] = b_dat[j*DW +: DW] ^ (64'h1 << $urandom_range(0, 63));
      end
      r = $urandom_range(0, 9);
      a_req  = (r < 2) || (r == 2);
      b_req  = (r < 2) || (r == 3);
      a_busy = ($urandom_range(0, 3) == 0);
      b_busy = ($urandom_range(0, 3) == 0);
      a_idle = ($urandom_range(0, 3) != 0);
      b_idle = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/is_flush_equiv_tracker.md
Name: is_flush_equiv_tracker

Overview:
- Synthesizable tracker for two-copy (A/B) equivalence runs of an is_core-class tile.
- Compares NUM_CH valid/data lane pairs and counts consecutive all-equal cycles.
- Detects a joint flush (invalidate) request, waits for both copies to drain, then checks output lanes for divergence.
- Drives phase flags that the formal harness binds to input-equality constraints and output checks. Also reports first-mismatch lane, flush timeout and a saturating equality counter.

Parameters:
NUM_CH, 8, number of compared lane pairs
DAT_W, 64, data width per lane
CNT_W, 5, width of equality-run counter
EQ_THRESH, 8, equality run length (cycles, must be > this) required before a flush may begin
FLUSH_TMO, 256, max cycles allowed in FLUSH before timeout; 0 disables timeout
OUT_MASK, {NUM_CH{1'b1}}, bit i set = lane i is a DUT output (checked after DONE); clear = DUT input (constrained)
DATA_GATE, 1, 1 = data compared only when both valids are high; 0 = data always compared

Ports:
clk_gated  in  1  clock
rst_f  in  1  synchronous active-high reset
a_val  in  NUM_CH  copy A lane valids
b_val  in  NUM_CH  copy B lane valids
a_dat  in  NUM_CH*DAT_W  copy A lane data, lane i at [i*DAT_W +: DAT_W]
b_dat  in  NUM_CH*DAT_W  copy B lane data
cmp_en  in  NUM_CH  per-lane compare enable; disabled lanes count as equal
a_flush_req, b_flush_req  in  1 each  invalidate-start strobe per copy
a_busy, b_busy  in  1 each  invalidate in progress per copy
a_idle, b_idle  in  1 each  no outstanding NoC requests per copy
state  out  2  0 IDLE, 1 FLUSH, 2 DONE, 3 ERR
flush_began  out  1  high from the cycle after flush start onward; cleared only by reset
flush_ended  out  1  high in DONE and ERR
io_equal  out  1  combinational: all enabled lanes equal this cycle
equal_cnt  out  CNT_W  consecutive io_equal cycles, saturating
mismatch  out  1  sticky: output lane diverged after DONE
mismatch_lane  out  $clog2(NUM_CH)  lowest diverging lane, captured on first mismatch
timeout  out  1  sticky: FLUSH exceeded FLUSH_TMO

Behaviour:
- Reset (rst_f=1 at posedge): state=IDLE, equal_cnt=0, flush_began=0, mismatch=0, mismatch_lane=0, timeout=0, internal flush timer=0. Reset mid-run aborts any phase with no residual state.
- Lane equal: (cmp_en[i]==0) or ((a_val[i]==b_val[i]) and data_ok).
  - data_ok = (a_dat lane == b_dat lane) when DATA_GATE=0.
  - data_ok = (!a_val[i] or a_dat==b_dat) when DATA_GATE=1.
- io_equal = AND of all lane-equal bits.
- equal_cnt: io_equal ? min(equal_cnt+1, 2^CNT_W-1) : 0. Saturates and never wraps. Updated in every state.
- start = (equal_cnt > EQ_THRESH) and io_equal and a_flush_req and b_flush_req. A request from only one copy is ignored.
- drained = !a_busy and !b_busy and a_idle and b_idle and no a_val/b_val bit set on any OUT_MASK lane.
- IDLE -> FLUSH on start. flush_began=1 from the next cycle. Timer cleared.
- FLUSH -> DONE when drained; flush_ended=1 from the next cycle.
  - Timer increments each FLUSH cycle.
  - If FLUSH_TMO!=0 and timer reaches FLUSH_TMO without drained: -> ERR and timeout=1.
  - If drained and timeout occur in the same cycle, drained wins (-> DONE).
- start and drained in the same IDLE cycle: go to FLUSH only. drained is evaluated starting with the first FLUSH cycle.
- DONE: every cycle, if any lane with OUT_MASK=1 and cmp_en=1 is unequal, set mismatch=1 and state -> ERR.
  - mismatch_lane captured only on the 0->1 edge of mismatch, priority to the lowest index.
- ERR: terminal until reset. Counters and io_equal keep updating; sticky flags hold.
- Input lanes (OUT_MASK=0) are never checked by this block. The harness constrains them equal while flush_began=1.
- Latency: io_equal combinational; all other outputs registered, 1 cycle after the causing condition.

Decomposition:
- Package is_equiv_pkg: state enum (IDLE/FLUSH/DONE/ERR), lane-index width function, default OUT_MASK constant.
- Sub-module is_lane_cmp: one lane-equality comparator (DATA_GATE-parametrised), instantiated NUM_CH times via generate.
- Lowest-index mismatch priority encoder stays inline.

Test Plan:
- All lanes equal for 10 cycles, then both flush_req=1 -> state=FLUSH next cycle, flush_began=1, equal_cnt=10.
- Equal run of 8 cycles only (equal_cnt=8, not > 8) with both flush_req -> stays IDLE. Repeat with a_flush_req only -> stays IDLE.
- FLUSH; a_busy drops at cycle 3, b_idle rises at cycle 5, valids low -> DONE after cycle 5, flush_ended=1.
- DONE; lanes 2 and 5 (outputs) differ on data with both valid -> mismatch=1, mismatch_lane=2, state=ERR. A later lane-1 mismatch leaves mismatch_lane=2.
- FLUSH_TMO=4, b_busy stuck high -> timeout=1, state=ERR after 4 FLUSH cycles. Repeat with drained on cycle 4 -> DONE, timeout=0.
- 40 equal cycles with CNT_W=5 -> equal_cnt holds at 31. Assert rst_f while in FLUSH -> all outputs return to reset values next cycle.
